// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and sign helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;
  localparam int MULDIV_ITERS = 32;
  localparam int CNT_W        = 5;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic [31:0] abs_op(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? -x : x;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// Pipeline-to-unit bundle: EX-stage request/move signals in, HI/LO and status out.
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            hilo_rd;
  logic            mthi;
  logic            mtlo;
  logic            flush;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            stall;
  logic            done;

  modport master (
    output start, op, rs_val, rt_val, hilo_rd, mthi, mtlo, flush,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  start, op, rs_val, rt_val, hilo_rd, mthi, mtlo, flush,
    output hi, lo, busy, stall, done
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// One iteration of the {HI,LO} accumulator: right shift-add for multiply,
// left shift restoring subtract for divide (quotient bits enter at LO[0]).
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opb_i,
  input  logic              is_div_i,
  output logic [2*XLEN-1:0] acc_o
);
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;
  logic            unused_diff;

  assign unused_diff = diff[XLEN];

  always_comb begin
    add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb_i} : '0);
    // rem_sh is the partial remainder after the left shift; it can carry one extra bit
    rem_sh  = acc_i[2*XLEN-1:XLEN-1];
    diff    = {1'b0, rem_sh} - {2'b00, opb_i};
    if (is_div_i) begin
      if (diff[XLEN+1]) acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      else              acc_o = {diff[XLEN-1:0],   acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: FSM, iteration counter, sign bookkeeping, HI/LO.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply path (divide stays iterative).
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave mdu
);
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   opb_q;
  logic              is_div_q;
  logic              qneg_q;
  logic              rneg_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              done_q;
  logic              op_signed;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .is_div_i (is_div_q),
    .acc_o    (acc_d)
  );

  assign op_signed = ~mdu.op[0];
  assign abs_a     = abs_op(mdu.rs_val, op_signed);
  assign abs_b     = abs_op(mdu.rt_val, op_signed);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (mdu.start && !mdu.flush) begin
            is_div_q <= mdu.op[1];
            opb_q    <= abs_b;
            qneg_q   <= op_signed & (mdu.rs_val[XLEN-1] ^ mdu.rt_val[XLEN-1]);
            rneg_q   <= op_signed & mdu.rs_val[XLEN-1];
            cnt_q    <= '0;
`ifdef MULDIV_FAST_MUL_EN
            if (!mdu.op[1]) begin
              acc_q   <= {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
              state_q <= S_FIX;
            end else begin
              acc_q   <= {{XLEN{1'b0}}, abs_a};
              state_q <= S_BUSY;
            end
`else
            acc_q   <= {{XLEN{1'b0}}, abs_a};
            state_q <= S_BUSY;
`endif
          end else begin
            // moves only land when no new operation claims the unit this cycle
            if (mdu.mthi) hi_q <= mdu.rs_val;
            if (mdu.mtlo) lo_q <= mdu.rs_val;
          end
        end
        S_BUSY: begin
          if (mdu.flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(MULDIV_ITERS - 1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          if (!mdu.flush) begin
            done_q <= 1'b1;
            if (is_div_q) begin
              lo_q <= neg_if(acc_q[XLEN-1:0], qneg_q);
              hi_q <= neg_if(acc_q[2*XLEN-1:XLEN], rneg_q);
            end else begin
              {hi_q, lo_q} <= qneg_q ? -acc_q : acc_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mdu.busy  = (state_q != S_IDLE);
  assign mdu.stall = mdu.busy & (mdu.start | mdu.hilo_rd | mdu.mthi | mdu.mtlo);
  assign mdu.hi    = hi_q;
  assign mdu.lo    = lo_q;
  assign mdu.done  = done_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: cycle-level reference model plus literal result checks.
module tb_muldiv_ctrl;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int MUL_LAT = FAST ? 2 : 34;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) mdu ();
  muldiv_ctrl #(.XLEN(32)) dut (.clk(clk), .rst(rst), .mdu(mdu));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int          rem_m = 0;
  logic [31:0] hi_m, lo_m;
  logic [63:0] pend_m;
  logic        done_m;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Architectural result {HI,LO} straight from the instruction definitions.
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, (sa < 0) ? 32'd1 : 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Model: counts remaining busy cycles; results appear when the count runs out.
  always @(posedge clk) begin
    if (rst) begin
      rem_m  <= 0;
      hi_m   <= 32'd0;
      lo_m   <= 32'd0;
      done_m <= 1'b0;
    end else begin
      done_m <= 1'b0;
      if (rem_m > 0) begin
        if (mdu.flush) rem_m <= 0;
        else begin
          rem_m <= rem_m - 1;
          if (rem_m == 1) begin
            hi_m   <= pend_m[63:32];
            lo_m   <= pend_m[31:0];
            done_m <= 1'b1;
          end
        end
      end else if (mdu.start && !mdu.flush) begin
        pend_m <= ref_res(mdu.op, mdu.rs_val, mdu.rt_val);
        rem_m  <= (FAST && !mdu.op[1]) ? 1 : 33;
      end else begin
        if (mdu.mthi) hi_m <= mdu.rs_val;
        if (mdu.mtlo) lo_m <= mdu.rs_val;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",  64'(mdu.busy),  64'(rem_m > 0));
      chk("done",  64'(mdu.done),  64'(done_m));
      chk("hi",    64'(mdu.hi),    64'(hi_m));
      chk("lo",    64'(mdu.lo),    64'(lo_m));
      chk("stall", 64'(mdu.stall),
          64'((rem_m > 0) && (mdu.start || mdu.hilo_rd || mdu.mthi || mdu.mtlo)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Entered in cycle 1 of an operation; returns the cycle number in which done is seen.
  task automatic wait_done(input int limit, output int cyc_n, output int busy_n);
    cyc_n  = 1;
    busy_n = 0;
    forever begin
      @(negedge clk);
      if (mdu.busy === 1'b1) busy_n++;
      if (mdu.done === 1'b1) return;
      if (cyc_n >= limit) begin
        chk("done_timeout", 64'(cyc_n), 64'(0));
        return;
      end
      @(posedge clk);
      #1;
      cyc_n++;
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int elat);
    int lat, bc;
    mdu.op = o; mdu.rs_val = a; mdu.rt_val = b; mdu.start = 1'b1;
    cyc();
    mdu.start = 1'b0;
    wait_done(60, lat, bc);
    chk({nm, "_lat"},  64'(lat),    64'(elat));
    chk({nm, "_busy"}, 64'(bc),     64'(elat - 1));
    chk({nm, "_hi"},   64'(mdu.hi), 64'(eh));
    chk({nm, "_lo"},   64'(mdu.lo), 64'(el));
    cyc();
    @(negedge clk);
    chk({nm, "_pulse"}, 64'(mdu.done), 64'(0));
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc;
    rst = 1'b1;
    mdu.start = 1'b0; mdu.op = 2'b00; mdu.rs_val = 32'd0; mdu.rt_val = 32'd0;
    mdu.hilo_rd = 1'b0; mdu.mthi = 1'b0; mdu.mtlo = 1'b0; mdu.flush = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(mdu.busy), 64'(0));
    chk("rst_hi",   64'(mdu.hi),   64'(0));
    chk("rst_lo",   64'(mdu.lo),   64'(0));
    chk("rst_done", 64'(mdu.done), 64'(0));
    cyc();

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    run_op("divu_zero", 2'b11, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 34);
    run_op("div_zero",  2'b10, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 34);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34);
    run_op("divu_std",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        34);
    run_op("multu_76",  2'b01, 32'd7,         32'd6,         32'd0,         32'd42,        MUL_LAT);

    // hilo_rd and a second start held from cycle 5 of a DIVU
    mdu.op = 2'b11; mdu.rs_val = 32'd1000; mdu.rt_val = 32'd10; mdu.start = 1'b1;
    cyc();
    mdu.start = 1'b0;
    repeat (4) cyc();
    mdu.hilo_rd = 1'b1; mdu.start = 1'b1; mdu.op = 2'b01; mdu.rs_val = 32'd3; mdu.rt_val = 32'd4;
    for (int c = 5; c <= 33; c++) begin
      @(negedge clk);
      chk("stall_held", 64'(mdu.stall), 64'(1));
      cyc();
    end
    @(negedge clk);
    chk("stall_clear", 64'(mdu.stall), 64'(0));
    chk("first_done",  64'(mdu.done),  64'(1));
    chk("first_lo",    64'(mdu.lo),    64'(100));
    cyc();
    mdu.start = 1'b0; mdu.hilo_rd = 1'b0;
    wait_done(60, lat, bc);
    chk("second_lat", 64'(lat),    64'(MUL_LAT));
    chk("second_lo",  64'(mdu.lo), 64'(12));
    cyc();

    // mtlo held while busy, lands once the unit is idle
    mdu.op = 2'b11; mdu.rs_val = 32'd9; mdu.rt_val = 32'd3; mdu.start = 1'b1;
    cyc();
    mdu.start = 1'b0; mdu.mtlo = 1'b1; mdu.rs_val = 32'h1234;
    wait_done(60, lat, bc);
    chk("mtlo_div_lo", 64'(mdu.lo), 64'(3));
    cyc();
    mdu.mtlo = 1'b0;
    @(negedge clk);
    chk("mtlo_retry", 64'(mdu.lo), 64'h1234);
    cyc();

    // flush in cycle 10 of a DIV
    mdu.mthi = 1'b1; mdu.rs_val = 32'hAAAA;
    cyc();
    mdu.mthi = 1'b0;
    mdu.op = 2'b10; mdu.rs_val = 32'd100; mdu.rt_val = 32'd7; mdu.start = 1'b1;
    cyc();
    mdu.start = 1'b0;
    repeat (9) cyc();
    mdu.flush = 1'b1;
    cyc();
    mdu.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(mdu.busy), 64'(0));
    chk("flush_hi",   64'(mdu.hi),   64'hAAAA);
    chk("flush_lo",   64'(mdu.lo),   64'h1234);
    cyc();
    repeat (30) cyc();

    // flush in IDLE suppresses start
    mdu.op = 2'b11; mdu.rs_val = 32'd8; mdu.rt_val = 32'd2; mdu.start = 1'b1; mdu.flush = 1'b1;
    cyc();
    mdu.start = 1'b0; mdu.flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_busy", 64'(mdu.busy), 64'(0));
    cyc();

    // start wins over a simultaneous mtlo
    mdu.op = 2'b01; mdu.rs_val = 32'd2; mdu.rt_val = 32'd3; mdu.start = 1'b1; mdu.mtlo = 1'b1;
    cyc();
    mdu.start = 1'b0; mdu.mtlo = 1'b0;
    wait_done(60, lat, bc);
    chk("start_prio_lo", 64'(mdu.lo), 64'(6));
    cyc();

    // reset in cycle 20 of a DIVU
    mdu.op = 2'b11; mdu.rs_val = 32'd77; mdu.rt_val = 32'd5; mdu.start = 1'b1;
    cyc();
    mdu.start = 1'b0;
    repeat (19) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(mdu.busy), 64'(0));
    chk("midrst_hi",   64'(mdu.hi),   64'(0));
    chk("midrst_lo",   64'(mdu.lo),   64'(0));
    chk("midrst_done", 64'(mdu.done), 64'(0));
    cyc();
    repeat (30) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
